vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_pkg.sv | 17 +
 rtl/vga_timing_axis.sv | 84 ++++++++
 rtl/vga_timing_ctrl.sv | 135 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared types and constants for the VGA timing generator.
//   COORD_W         : width of the x/y coordinate outputs and internal counters.
//   COORD_MAX_TOTAL : largest total line/frame length representable in COORD_W bits.
//   phase_t         : phase of one timing axis (visible, front porch, sync, back porch).
package vga_timing_pkg;

  localparam int COORD_W         = 12;
  localparam int COORD_MAX_TOTAL = 1 << COORD_W;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_timing_axis.sv
// vga_timing_axis: one timing axis (horizontal or vertical) of the VGA generator.
// A position counter runs 0..TOTAL-1 and a phase FSM walks
// ACTIVE -> FP -> SYNC -> BP -> ACTIVE, leaving each phase on the advance cycle
// where the counter sits on that phase's last index.
// Ports:
//   pix_clk : pixel clock, rising edge
//   rst     : synchronous active-high reset (count 0, phase ACTIVE)
//   advance : step the counter and FSM this cycle
//   count   : current position
//   phase   : current phase
//   wrap    : count is on the last index (next advance wraps to 0)
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACT_LEN  = 640,
  parameter int FP_LEN   = 16,
  parameter int SYNC_LEN = 96,
  parameter int BP_LEN   = 48
) (
  input  logic               pix_clk,
  input  logic               rst,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output phase_t             phase,
  output logic               wrap
);

  localparam int TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  localparam logic [COORD_W-1:0] L_ACT  = COORD_W'(ACT_LEN - 1);
  localparam logic [COORD_W-1:0] L_FP   = COORD_W'(ACT_LEN + FP_LEN - 1);
  localparam logic [COORD_W-1:0] L_SYNC = COORD_W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [COORD_W-1:0] L_BP   = COORD_W'(TOTAL - 1);

  if (TOTAL > COORD_MAX_TOTAL) begin : g_chk_total
    $error("vga_timing_axis: total length %0d exceeds %0d", TOTAL, COORD_MAX_TOTAL);
  end
  if (FP_LEN < 1 || SYNC_LEN < 1 || BP_LEN < 1) begin : g_chk_porch
    $error("vga_timing_axis: porch and sync lengths must all be at least 1");
  end

  logic [COORD_W-1:0] r_count;
  phase_t             r_phase;
  logic [COORD_W-1:0] w_count_nxt;
  phase_t             w_phase_nxt;
  logic               w_last;

  assign w_last = (r_count == L_BP);

  // State register
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_count <= '0;
      r_phase <= ACTIVE;
    end else begin
      r_count <= w_count_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next state
  always_comb begin
    w_count_nxt = r_count;
    w_phase_nxt = r_phase;
    if (advance) begin
      w_count_nxt = w_last ? '0 : r_count + COORD_W'(1);
      unique case (r_phase)
        ACTIVE: if (r_count == L_ACT)  w_phase_nxt = FP;
        FP:     if (r_count == L_FP)   w_phase_nxt = SYNC;
        SYNC:   if (r_count == L_SYNC) w_phase_nxt = BP;
        BP:     if (w_last)            w_phase_nxt = ACTIVE;
        default:                       w_phase_nxt = ACTIVE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    count = r_count;
    phase = r_phase;
    wrap  = w_last;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA sync/timing generator.
// Two vga_timing_axis instances (horizontal, vertical); the vertical axis steps
// only on enabled cycles where the horizontal axis wraps. All outputs are
// registered from the pre-increment counter/phase values and change only on
// enabled cycles (one enabled-cycle latency); the strobes are 0 when en is low.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds the frame_cnt output.
// Ports:
//   pix_clk     : pixel clock, rising edge
//   rst         : synchronous active-high reset
//   en          : pixel-advance enable
//   hsync/vsync : sync pulses, asserted level HSYNC_POL / VSYNC_POL
//   video_on    : current position is visible
//   x, y        : current horizontal / vertical count
//   line_start  : strobe, x == 0 on this enabled cycle
//   frame_start : strobe, x == 0 and y == 0 on this enabled cycle
//   frame_cnt   : frame_start pulse counter (only with VGA_TIMING_FRAME_CNT_EN)
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic               pix_clk,
  input  logic               rst,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  logic [COORD_W-1:0] w_h_count, w_v_count;
  phase_t             w_h_phase, w_v_phase;
  logic               w_h_wrap, w_v_wrap, w_v_adv;

  logic [COORD_W-1:0] r_x, r_y;
  logic               r_hsync, r_vsync, r_video_on, r_line_start, r_frame_start;

  assign w_v_adv = en & w_h_wrap;

  vga_timing_axis #(
    .ACT_LEN (H_ACTIVE),
    .FP_LEN  (H_FP),
    .SYNC_LEN(H_SYNC),
    .BP_LEN  (H_BP)
  ) u_h_axis (
    .pix_clk(pix_clk),
    .rst    (rst),
    .advance(en),
    .count  (w_h_count),
    .phase  (w_h_phase),
    .wrap   (w_h_wrap)
  );

  vga_timing_axis #(
    .ACT_LEN (V_ACTIVE),
    .FP_LEN  (V_FP),
    .SYNC_LEN(V_SYNC),
    .BP_LEN  (V_BP)
  ) u_v_axis (
    .pix_clk(pix_clk),
    .rst    (rst),
    .advance(w_v_adv),
    .count  (w_v_count),
    .phase  (w_v_phase),
    .wrap   (w_v_wrap)
  );

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (en) begin
        r_x           <= w_h_count;
        r_y           <= w_v_count;
        r_hsync       <= (w_h_phase == SYNC) ? HSYNC_POL : ~HSYNC_POL;
        r_vsync       <= (w_v_phase == SYNC) ? VSYNC_POL : ~VSYNC_POL;
        r_video_on    <= (w_h_phase == ACTIVE) && (w_v_phase == ACTIVE);
        r_line_start  <= (w_h_count == '0);
        r_frame_start <= (w_h_count == '0) && (w_v_count == '0);
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts each cycle on which the registered frame_start strobe is high.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (r_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  // Both axes wrap only from their back porch, since every porch is non-empty.
  a_h_wrap_in_bp: assert property (@(posedge pix_clk) disable iff (rst) w_h_wrap |-> (w_h_phase == BP));
  a_v_wrap_in_bp: assert property (@(posedge pix_clk) disable iff (rst) w_v_wrap |-> (w_v_phase == BP));

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: self-checking bench for vga_timing_ctrl with a reduced
// raster so several frames fit in a short run. A position-based model derives
// every expected output from plain arithmetic on (h, v); a compare process
// checks all outputs on every falling edge, and directed sequences pin literal
// values at the interesting boundaries before a randomized en/rst phase.
module tb_vga_timing_ctrl;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;

  logic        pix_clk;
  logic        rst, en;
  logic        hsync, vsync, video_on, line_start, frame_start;
  logic [11:0] x, y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vga_timing_ctrl #(
    .H_ACTIVE (HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE (VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut (
    .pix_clk    (pix_clk),
    .rst        (rst),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .line_start (line_start),
    .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raster position plus expected registered outputs.
  int   mh = 0, mv = 0;
  bit   valid = 0;
  int   exp_x = 0, exp_y = 0, exp_fc = 0;
  logic exp_hs, exp_vs, exp_vo, exp_ls, exp_fs;

  always @(posedge pix_clk) begin
    if (rst) begin
      mh = 0; mv = 0;
      exp_x = 0; exp_y = 0; exp_vo = 0;
      exp_hs = !HPOL; exp_vs = !VPOL;
      exp_ls = 0; exp_fs = 0; exp_fc = 0;
      valid = 1;
    end else begin
      if (exp_fs) exp_fc = (exp_fc + 1) % 65536;
      if (en) begin
        exp_x  = mh;
        exp_y  = mv;
        exp_hs = (mh >= HA + HF && mh < HA + HF + HS) ? HPOL : !HPOL;
        exp_vs = (mv >= VA + VF && mv < VA + VF + VS) ? VPOL : !VPOL;
        exp_vo = (mh < HA) && (mv < VA);
        exp_ls = (mh == 0);
        exp_fs = (mh == 0) && (mv == 0);
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv = (mv + 1) % VT;
        end
      end else begin
        exp_ls = 0;
        exp_fs = 0;
      end
    end
  end

  // Compare process: every cycle once a reset has been applied.
  always @(negedge pix_clk) begin
    if (valid) begin
      chk("x",           32'(x),           32'(exp_x));
      chk("y",           32'(y),           32'(exp_y));
      chk("hsync",       32'(hsync),       32'(exp_hs));
      chk("vsync",       32'(vsync),       32'(exp_vs));
      chk("video_on",    32'(video_on),    32'(exp_vo));
      chk("line_start",  32'(line_start),  32'(exp_ls));
      chk("frame_start", 32'(frame_start), 32'(exp_fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("frame_cnt",   32'(frame_cnt),   32'(exp_fc));
`endif
    end
  end

  // Drive inputs for one cycle; returns at the next falling edge.
  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    @(negedge pix_clk);
  endtask

  task automatic run_to(input int tx, input int ty, input string name);
    bit found = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (x == 12'(tx) && y == 12'(ty)) begin
        found = 1;
        break;
      end
      step(1'b0, 1'b1);
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    int   hc, vc, n;
    logic [11:0] py;
    bit   found;
    rst = 1'b1;
    en  = 1'b0;
    @(negedge pix_clk);

    // Reset with en low still resets.
    repeat (3) step(1'b1, 1'b0);
    chk("rst_x",        32'(x),          32'd0);
    chk("rst_video_on", 32'(video_on),   32'd0);
    chk("rst_hsync",    32'(hsync),      32'(!HPOL));
    chk("rst_vsync",    32'(vsync),      32'(!VPOL));
    chk("rst_ls",       32'(line_start), 32'd0);

    // First enabled cycle after reset.
    step(1'b0, 1'b1);
    chk("c1_x",  32'(x),           32'd0);
    chk("c1_y",  32'(y),           32'd0);
    chk("c1_vo", 32'(video_on),    32'd1);
    chk("c1_ls", 32'(line_start),  32'd1);
    chk("c1_fs", 32'(frame_start), 32'd1);

    // First line: visible edge, hsync placement and width, line wrap.
    hc = 0;
    for (int i = 0; i < HT; i++) begin
      if (hsync === HPOL) hc++;
      if (i == HA - 1) begin
        chk("last_vis_x",  32'(x), 32'(HA - 1));
        chk("last_vis_vo", 32'(video_on), 32'd1);
      end
      if (i == HA) begin
        chk("first_blank_x",  32'(x), 32'(HA));
        chk("first_blank_vo", 32'(video_on), 32'd0);
      end
      if (i == HA + HF - 1) chk("hsync_before", 32'(hsync), 32'(!HPOL));
      if (i == HA + HF)     chk("hsync_first",  32'(hsync), 32'(HPOL));
      step(1'b0, 1'b1);
    end
    chk("hsync_width", 32'(hc), 32'(HS));
    chk("wrap_x",  32'(x),          32'd0);
    chk("wrap_y",  32'(y),          32'd1);
    chk("wrap_ls", 32'(line_start), 32'd1);

    // Frame period, y wrap and vsync width.
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (frame_start === 1'b1) begin
        found = 1;
        break;
      end
      step(1'b0, 1'b1);
    end
    chk("reach_frame_start", 32'(found), 32'd1);
    n = 0;
    vc = 0;
    py = y;
    do begin
      py = y;
      step(1'b0, 1'b1);
      n++;
      if (vsync === VPOL) vc++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME);
    chk("frame_period", 32'(n),  32'(FRAME));
    chk("y_before_wrap", 32'(py), 32'(VT - 1));
    chk("vsync_cycles", 32'(vc), 32'(VS * HT));

    // en low: everything holds, strobes stay 0.
    run_to(5, 2, "reach_x5");
    repeat (6) begin
      step(1'b0, 1'b0);
      chk("hold_x",  32'(x),          32'd5);
      chk("hold_y",  32'(y),          32'd2);
      chk("hold_ls", 32'(line_start), 32'd0);
    end
    step(1'b0, 1'b1);
    chk("resume_x", 32'(x), 32'd6);

    // Reset mid-frame abandons the frame.
    run_to(20, 3, "reach_x20_y3");
    step(1'b1, 1'b1);
    chk("mid_rst_x",  32'(x),        32'd0);
    chk("mid_rst_y",  32'(y),        32'd0);
    chk("mid_rst_vo", 32'(video_on), 32'd0);
    chk("mid_rst_hs", 32'(hsync),    32'(!HPOL));
    step(1'b0, 1'b1);
    chk("post_rst_fs", 32'(frame_start), 32'd1);
    chk("post_rst_x",  32'(x),           32'd0);
    chk("post_rst_y",  32'(y),           32'd0);
    chk("post_rst_vo", 32'(video_on),    32'd1);

    // Randomized enable with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
